// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: FSM encodings, board timing defaults and sizing helper for the SRAM burst controller
package sram_ctrl_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_SETUP  = 3'd1;
    localparam logic [2:0] S_RD_ACCESS = 3'd2;
    localparam logic [2:0] S_RD_END    = 3'd3;
    localparam logic [2:0] S_WR_SETUP  = 3'd4;
    localparam logic [2:0] S_WR_PULSE  = 3'd5;
    localparam logic [2:0] S_WR_HOLD   = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        RD_SETUP  = S_RD_SETUP,
        RD_ACCESS = S_RD_ACCESS,
        RD_END    = S_RD_END,
        WR_SETUP  = S_WR_SETUP,
        WR_PULSE  = S_WR_PULSE,
        WR_HOLD   = S_WR_HOLD
    } state_t;

    // 10 ns part at 100 MHz: one cycle meets tAA/tWP, the second absorbs pad and board delay
    localparam int DEF_RD_WAIT = 2;
    localparam int DEF_WR_WAIT = 2;

    // width of a down-counter that must hold the larger of the two wait counts
    function automatic int wait_w(input int rd, input int wr);
        return $clog2((rd > wr ? rd : wr) + 1);
    endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// sram_burst_ctrl_if: request/response bundle between client logic and the SRAM burst controller
//   master: start, rw, addr, len_m1, wr_data out; wr_next, rd_data, rd_valid, wr_done, busy in
//   slave : the mirror image, used by the controller
interface sram_burst_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len_m1;
    logic [DATA_W-1:0] wr_data;
    logic              wr_next;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_done;
    logic              busy;

    modport master (
        output start, rw, addr, len_m1, wr_data,
        input  wr_next, rd_data, rd_valid, wr_done, busy
    );

    modport slave (
        input  start, rw, addr, len_m1, wr_data,
        output wr_next, rd_data, rd_valid, wr_done, busy
    );
endinterface

// File: rtl/sram_wait_timer.sv
// sram_wait_timer: loadable down-counter that flags when it has run out
//   clk, reset : clock and async active-high reset
//   load, val  : load val on the next edge (takes priority over counting)
//   done       : count is zero; the counter then holds until reloaded
module sram_wait_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = cnt == '0;
endmodule

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: burst read/write controller for an asynchronous SRAM with a shared tristate data bus
//   clk, reset      : clock and async active-high reset (aborts any SRAM cycle)
//   bus (slave)     : start/rw/addr/len_m1/wr_data request, wr_next/rd_data/rd_valid/wr_done/busy response
//   sram_addr       : registered SRAM address, auto-incremented (wrapping) within a burst
//   sram_ce_n/oe_n/we_n : active-low SRAM strobes, all registered
//   sram_dq         : data bus, driven only while a write word is on the pins
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 8,
    parameter int RD_WAIT = DEF_RD_WAIT,
    parameter int WR_WAIT = DEF_WR_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    sram_burst_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    inout  wire  [DATA_W-1:0] sram_dq
);
    if (RD_WAIT < 1 || WR_WAIT < 1) begin : g_bad_wait
        $error("sram_burst_ctrl: RD_WAIT and WR_WAIT must both be at least 1");
    end

    localparam int WT_W = wait_w(RD_WAIT, WR_WAIT);
    // timer counts down to zero, so a W-cycle window loads W-1
    localparam logic [WT_W-1:0] RD_LOAD = WT_W'(RD_WAIT - 1);
    localparam logic [WT_W-1:0] WR_LOAD = WT_W'(WR_WAIT - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wdat_q, wdat_d, rd_data_q, rd_data_d;
    logic              ce_n_d, oe_n_d, we_n_d;
    logic              dq_oe, dq_oe_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_next_q, wr_next_d;
    logic              wr_done_q, wr_done_d;
    logic              busy_q, busy_d;
    logic              t_load, t_done;
    logic [WT_W-1:0]   t_val;
    logic              last;

    sram_wait_timer #(.W(WT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (t_load),
        .val   (t_val),
        .done  (t_done)
    );

    assign last         = cnt_q == '0;
    assign sram_dq      = dq_oe ? wdat_q : 'z;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_next  = wr_next_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.busy     = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_addr  <= '0;
            cnt_q      <= '0;
            wdat_q     <= '0;
            rd_data_q  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            dq_oe      <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_next_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sram_addr  <= addr_d;
            cnt_q      <= cnt_d;
            wdat_q     <= wdat_d;
            rd_data_q  <= rd_data_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            dq_oe      <= dq_oe_d;
            rd_valid_q <= rd_valid_d;
            wr_next_q  <= wr_next_d;
            wr_done_q  <= wr_done_d;
            busy_q     <= busy_d;
        end
    end

    // next-state and next-output values; every output is the registered copy of these
    always_comb begin
        state_d    = state;
        addr_d     = sram_addr;
        cnt_d      = cnt_q;
        wdat_d     = wdat_q;
        rd_data_d  = rd_data_q;
        ce_n_d     = sram_ce_n;
        oe_n_d     = sram_oe_n;
        we_n_d     = sram_we_n;
        dq_oe_d    = dq_oe;
        rd_valid_d = 1'b0;
        wr_next_d  = 1'b0;
        wr_done_d  = 1'b0;
        busy_d     = busy_q;
        t_load     = 1'b0;
        t_val      = '0;
        case (state)
            IDLE: if (bus.start) begin
                addr_d = bus.addr;
                cnt_d  = bus.len_m1;
                busy_d = 1'b1;
                if (bus.rw) begin
                    state_d = RD_SETUP;
                end else begin
                    state_d = WR_SETUP;
                    wdat_d  = bus.wr_data;
                    ce_n_d  = 1'b0;
                    dq_oe_d = 1'b1;
                end
            end
            RD_SETUP: begin
                state_d = RD_ACCESS;
                ce_n_d  = 1'b0;
                oe_n_d  = 1'b0;
                t_load  = 1'b1;
                t_val   = RD_LOAD;
            end
            // strobes stay low across words; only the address steps between them
            RD_ACCESS: if (t_done) begin
                rd_data_d  = sram_dq;
                rd_valid_d = 1'b1;
                if (last) begin
                    state_d = RD_END;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end else begin
                    addr_d = sram_addr + ADDR_W'(1);
                    cnt_d  = cnt_q - LEN_W'(1);
                    t_load = 1'b1;
                    t_val  = RD_LOAD;
                end
            end
            RD_END: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                we_n_d  = 1'b0;
                t_load  = 1'b1;
                t_val   = WR_LOAD;
            end
            WR_PULSE: if (t_done) begin
                state_d   = WR_HOLD;
                we_n_d    = 1'b1;
                wr_next_d = !last;
                wr_done_d = last;
            end
            // data stays on the bus one cycle past WE# rising for hold time
            WR_HOLD: if (last) begin
                state_d = IDLE;
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                busy_d  = 1'b0;
            end else begin
                state_d = WR_SETUP;
                addr_d  = sram_addr + ADDR_W'(1);
                cnt_d   = cnt_q - LEN_W'(1);
                wdat_d  = bus.wr_data;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb_sram_burst_ctrl: randomized bench against a word-level SRAM reference model for two controller configurations
module tb_sram_burst_ctrl;
    localparam int RW_A = 2;
    localparam int WW_A = 2;
    localparam int RW_B = 1;
    localparam int WW_B = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // configuration A: default widths and waits
    sram_burst_ctrl_if #(.ADDR_W(19), .DATA_W(8), .LEN_W(8)) ia ();
    logic [18:0] sa_addr;
    logic        sa_ce_n, sa_oe_n, sa_we_n;
    wire  [7:0]  sa_dq;

    sram_burst_ctrl #(.ADDR_W(19), .DATA_W(8), .LEN_W(8), .RD_WAIT(RW_A), .WR_WAIT(WW_A)) dut_a (
        .clk(clk), .reset(reset), .bus(ia),
        .sram_addr(sa_addr), .sram_ce_n(sa_ce_n), .sram_oe_n(sa_oe_n), .sram_we_n(sa_we_n), .sram_dq(sa_dq)
    );

    // configuration B: wide data, asymmetric waits, small address space to exercise wrap
    sram_burst_ctrl_if #(.ADDR_W(10), .DATA_W(16), .LEN_W(8)) ib ();
    logic [9:0]  sb_addr;
    logic        sb_ce_n, sb_oe_n, sb_we_n;
    wire  [15:0] sb_dq;

    sram_burst_ctrl #(.ADDR_W(10), .DATA_W(16), .LEN_W(8), .RD_WAIT(RW_B), .WR_WAIT(WW_B)) dut_b (
        .clk(clk), .reset(reset), .bus(ib),
        .sram_addr(sb_addr), .sram_ce_n(sb_ce_n), .sram_oe_n(sb_oe_n), .sram_we_n(sb_we_n), .sram_dq(sb_dq)
    );

    // physical SRAM models: drive on CE#&OE# low, store on WE# rising
    logic [7:0]  mem_a [0:(1<<19)-1];
    logic [15:0] mem_b [0:1023];
    assign sa_dq = (!sa_ce_n && !sa_oe_n && sa_we_n) ? mem_a[sa_addr] : 'z;
    assign sb_dq = (!sb_ce_n && !sb_oe_n && sb_we_n) ? mem_b[sb_addr] : 'z;

    logic [18:0] wl_addr [$];
    logic [7:0]  wl_data [$];
    logic [9:0]  wlb_addr [$];
    logic [15:0] wlb_data [$];
    logic [18:0] pa_addr = '0, pv_addr = '0;
    logic [7:0]  pa_data = '0;
    logic        pv_we = 1'b1, pvb_we = 1'b1;
    logic [9:0]  pb_addr = '0;
    logic [15:0] pb_data = '0;
    bit          mon_en = 1'b1;
    int          inv_a = 0, cont_a = 0, cont_b = 0;

    always @(negedge clk) begin
        if (!sa_oe_n && dut_a.dq_oe) cont_a++;
        if (mon_en && sa_addr != pv_addr && (!sa_we_n || !pv_we)) inv_a++;
        if (mon_en && pv_we && !sa_we_n && (sa_ce_n || sa_addr != pv_addr)) inv_a++;
        if (!pv_we && sa_we_n) begin
            mem_a[pa_addr] = pa_data;
            wl_addr.push_back(pa_addr);
            wl_data.push_back(pa_data);
        end
        if (!sa_we_n) begin
            pa_addr = sa_addr;
            pa_data = sa_dq;
        end
        pv_we   = sa_we_n;
        pv_addr = sa_addr;
    end

    always @(negedge clk) begin
        if (!sb_oe_n && dut_b.dq_oe) cont_b++;
        if (!pvb_we && sb_we_n) begin
            mem_b[pb_addr] = pb_data;
            wlb_addr.push_back(pb_addr);
            wlb_data.push_back(pb_data);
        end
        if (!sb_we_n) begin
            pb_addr = sb_addr;
            pb_data = sb_dq;
        end
        pvb_we = sb_we_n;
    end

    // reference: what each address should hold, plus the words queued for the next write burst
    logic [7:0]  ref_a [logic [18:0]];
    logic [15:0] ref_b [logic [9:0]];
    logic [7:0]  wq [$];
    logic [15:0] wqb [$];

    task automatic op_a(input bit rw, input logic [18:0] a, input int n, input string tag);
        int k = 0, wi = 1, w = 0, nrv = 0, nwn = 0, nwd = 0, nwe = 0, noe = 0, ndrv = 0, derr = 0, werr = 0, bend = -1;
        logic [18:0] ea;
        @(negedge clk);
        ia.start = 1'b1; ia.rw = rw; ia.addr = a; ia.len_m1 = 8'(n - 1); ia.wr_data = rw ? 8'h00 : wq[0];
        @(posedge clk);
        while (bend < 0 && k < 3000) begin
            @(negedge clk);
            k++;
            ia.start = 1'b0;
            if (ia.wr_next) begin
                nwn++;
                if (wi < n) ia.wr_data = wq[wi];
                wi++;
            end
            if (ia.wr_done) nwd++;
            if (!sa_we_n) nwe++;
            if (!sa_oe_n) noe++;
            if (dut_a.dq_oe) begin
                ndrv++;
                w = (k - 1) / (WW_A + 2);
                if (rw || w >= n || sa_dq !== wq[w]) derr++;
            end
            if (ia.rd_valid) begin
                ea = a + 19'(nrv);
                if (k != 2 + RW_A * (nrv + 1) || !ref_a.exists(ea) || ia.rd_data !== ref_a[ea]) derr++;
                nrv++;
            end
            if (!ia.busy) bend = k;
        end
        chk({tag, "_busy_end"}, bend, rw ? 3 + RW_A * n : n * (WW_A + 2) + 1);
        chk({tag, "_data"}, derr, 0);
        if (rw) begin
            chk({tag, "_rd_valid_cnt"}, nrv, n);
            chk({tag, "_oe_low"}, noe, RW_A * n);
            chk({tag, "_dq_driven"}, ndrv, 0);
        end else begin
            chk({tag, "_we_low"}, nwe, WW_A * n);
            chk({tag, "_wr_next_cnt"}, nwn, n - 1);
            chk({tag, "_wr_done_cnt"}, nwd, 1);
            chk({tag, "_dq_driven"}, ndrv, (WW_A + 2) * n);
            for (int i = 0; i < n; i++) begin
                if (i >= wl_addr.size() || wl_addr[i] != a + 19'(i) || wl_data[i] !== wq[i]) werr++;
                ref_a[a + 19'(i)] = wq[i];
            end
            chk({tag, "_wlog_cnt"}, wl_addr.size(), n);
            chk({tag, "_wlog"}, werr, 0);
        end
        wl_addr.delete();
        wl_data.delete();
    endtask

    task automatic op_b(input bit rw, input logic [9:0] a, input int n, input string tag);
        int k = 0, wi = 1, nrv = 0, nwn = 0, nwd = 0, ndrv = 0, derr = 0, werr = 0, bend = -1;
        logic [9:0] ea;
        @(negedge clk);
        ib.start = 1'b1; ib.rw = rw; ib.addr = a; ib.len_m1 = 8'(n - 1); ib.wr_data = rw ? 16'h0 : wqb[0];
        @(posedge clk);
        while (bend < 0 && k < 5000) begin
            @(negedge clk);
            k++;
            ib.start = 1'b0;
            if (ib.wr_next) begin
                nwn++;
                if (wi < n) ib.wr_data = wqb[wi];
                wi++;
            end
            if (ib.wr_done) nwd++;
            if (dut_b.dq_oe) ndrv++;
            if (ib.rd_valid) begin
                ea = a + 10'(nrv);
                if (k != 2 + RW_B * (nrv + 1) || !ref_b.exists(ea) || ib.rd_data !== ref_b[ea]) derr++;
                nrv++;
            end
            if (!ib.busy) bend = k;
        end
        chk({tag, "_busy_end"}, bend, rw ? 3 + RW_B * n : n * (WW_B + 2) + 1);
        chk({tag, "_data"}, derr, 0);
        if (rw) begin
            chk({tag, "_rd_valid_cnt"}, nrv, n);
            chk({tag, "_dq_driven"}, ndrv, 0);
        end else begin
            chk({tag, "_wr_next_cnt"}, nwn, n - 1);
            chk({tag, "_wr_done_cnt"}, nwd, 1);
            chk({tag, "_dq_driven"}, ndrv, (WW_B + 2) * n);
            for (int i = 0; i < n; i++) begin
                if (i >= wlb_addr.size() || wlb_addr[i] != a + 10'(i) || wlb_data[i] !== wqb[i]) werr++;
                ref_b[a + 10'(i)] = wqb[i];
            end
            chk({tag, "_wlog_cnt"}, wlb_addr.size(), n);
            chk({tag, "_wlog"}, werr, 0);
        end
        wlb_addr.delete();
        wlb_data.delete();
    endtask

    initial begin
        int nops, nrv, derr;
        logic pb;
        logic [18:0] ra;
        int rn;
        ia.start = 1'b0; ia.rw = 1'b0; ia.addr = '0; ia.len_m1 = '0; ia.wr_data = '0;
        ib.start = 1'b0; ib.rw = 1'b0; ib.addr = '0; ib.len_m1 = '0; ib.wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ce_n", sa_ce_n, 1'b1);
        chk("rst_oe_n", sa_oe_n, 1'b1);
        chk("rst_we_n", sa_we_n, 1'b1);
        chk("rst_dq_oe", dut_a.dq_oe, 1'b0);
        chk("rst_busy", ia.busy, 1'b0);
        chk("rst_rd_valid", ia.rd_valid, 1'b0);
        chk("rst_wr_next", ia.wr_next, 1'b0);
        chk("rst_wr_done", ia.wr_done, 1'b0);
        chk("rst_rd_data", ia.rd_data, 8'h00);
        chk("rst_sram_addr", sa_addr, 19'h0);
        reset = 1'b0;

        wq = '{8'hA5};
        op_a(1'b0, 19'h00010, 1, "wr1");
        op_a(1'b1, 19'h00010, 1, "rd1");
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        op_a(1'b0, 19'h7FFFE, 4, "wr_wrap");
        op_a(1'b1, 19'h7FFFE, 4, "rd_wrap");

        // start held high across three back-to-back single-word reads
        @(negedge clk);
        ia.start = 1'b1; ia.rw = 1'b1; ia.addr = 19'h00010; ia.len_m1 = 8'd0;
        nops = 0; nrv = 0; derr = 0; pb = 1'b0;
        repeat (3 * (3 + RW_A)) begin
            @(negedge clk);
            if (ia.busy && !pb) nops++;
            pb = ia.busy;
            if (ia.rd_valid) begin
                nrv++;
                if (ia.rd_data !== ref_a[19'h00010]) derr++;
            end
        end
        ia.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_ops", nops, 3);
        chk("hold_rd_valid", nrv, 3);
        chk("hold_data", derr, 0);
        chk("hold_idle", ia.busy, 1'b0);

        // reset in the second WE# low cycle of a four-word write burst
        wq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        @(negedge clk);
        ia.start = 1'b1; ia.rw = 1'b0; ia.addr = 19'h00100; ia.len_m1 = 8'd3; ia.wr_data = wq[0];
        @(negedge clk);
        ia.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_we_n_low", sa_we_n, 1'b0);
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_we_n", sa_we_n, 1'b1);
        chk("arst_ce_n", sa_ce_n, 1'b1);
        chk("arst_dq_oe", dut_a.dq_oe, 1'b0);
        chk("arst_busy", ia.busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wl_addr.delete();
        wl_data.delete();
        mon_en = 1'b1;
        op_a(1'b1, 19'h00010, 1, "rd_after_rst");

        for (int it = 0; it < 4; it++) begin
            ra = (it == 0) ? 19'h7FFFD : 19'($urandom);
            rn = $urandom_range(1, 6);
            wq.delete();
            for (int i = 0; i < rn; i++) wq.push_back(8'($urandom));
            op_a(1'b0, ra, rn, "rnd_wr");
            op_a(1'b1, ra, rn, "rnd_rd");
        end

        wqb.delete();
        for (int i = 0; i < 256; i++) wqb.push_back(16'($urandom));
        op_b(1'b0, 10'h3F0, 256, "b_wr256");
        op_b(1'b1, 10'h3F0, 256, "b_rd256");

        chk("a_invariants", inv_a, 0);
        chk("a_contention", cont_a, 0);
        chk("b_contention", cont_b, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
Parametrised successor to the team's single-byte asynchronous SRAM controller. It generalises address and data width and per-access wait states, and adds multi-word bursts with address auto-increment and a per-word write-data handshake. It sits between FPGA-side test/DMA logic and the external asynchronous SRAM pins (CE#/OE#/WE#, shared tristate DQ bus).

Parameters:
ADDR_W, 19, SRAM address width; burst address wraps modulo 2^ADDR_W
DATA_W, 8, SRAM data width
LEN_W, 8, width of burst length field (max burst 2^LEN_W words)
RD_WAIT, 2, cycles CE#/OE# held low per read word (>=1)
WR_WAIT, 2, cycles WE# held low per write word (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
rw  in  1  1=read, 0=write; sampled with start
addr  in  ADDR_W  first word address; sampled with start
len_m1  in  LEN_W  burst length minus one; sampled with start
wr_data  in  DATA_W  write word; sampled with start (word 0) and in each wr_next cycle
wr_next  out  1  one-cycle pulse: next write word is captured from wr_data this cycle
rd_data  out  DATA_W  registered read word
rd_valid  out  1  one-cycle pulse per read word; rd_data valid in that cycle
wr_done  out  1  one-cycle pulse when the last write word completes
busy  out  1  high from the cycle after start acceptance until return to IDLE
sram_addr  out  ADDR_W  registered SRAM address
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM controls
sram_dq  inout  DATA_W  SRAM data bus, driven only during write states

Behaviour:
- Reset (async, immediate, also mid-burst): state IDLE; ce_n=oe_n=we_n=1; dq released (Z); busy, rd_valid, wr_next, wr_done = 0; rd_data = 0; sram_addr = 0; word counter = 0. Any in-flight SRAM cycle is aborted.
- All outputs are registered. start is ignored while busy=1.
- States: IDLE, RD_SETUP, RD_ACCESS, RD_END, WR_SETUP, WR_PULSE, WR_HOLD.
- Read, start accepted at edge T0:
  - T0+1, RD_SETUP: busy=1; sram_addr=addr; ce_n=oe_n=1.
  - T0+2 through T0+1+RD_WAIT, RD_ACCESS: ce_n=oe_n=0; we_n=1.
  - At the last access edge: rd_data<=sram_dq.
  - Next cycle rd_valid=1. If more words remain, sram_addr increments in that same cycle and the FSM stays in RD_ACCESS with ce_n/oe_n held low (RD_WAIT cycles per word, no gap).
  - After the last word: RD_END, with rd_valid=1, ce_n=oe_n=1, busy=1; then IDLE with busy=0.
  - Single-word read latency: rd_valid at T0+2+RD_WAIT.
- Write, start accepted at T0; wr_data latched at T0:
  - WR_SETUP (1 cycle): ce_n=0; we_n=oe_n=1; dq driven with the latched word.
  - WR_PULSE (WR_WAIT cycles): we_n=0; dq driven.
  - WR_HOLD (1 cycle): we_n=1; ce_n=0; dq still driven (hold time).
    - More words remain: wr_next=1 and wr_data is captured; next cycle sram_addr+1, WR_SETUP.
    - Last word: wr_done=1; next cycle IDLE with ce_n=1, dq released, busy=0.
  - Each write word costs WR_WAIT+2 cycles.
- Invariants:
  - oe_n=0 and dq driven never occur in the same cycle.
  - we_n falls only while sram_addr is stable and ce_n=0.
  - sram_addr changes only while we_n=1.
- Counter: down-counts from len_m1; the burst ends when the counter reaches 0.
- len_m1 = 2^LEN_W - 1 gives the maximum burst with no overflow.
- Address wraps from 2^ADDR_W - 1 to 0 within a burst.
- Wait-state counter width is clog2(max(RD_WAIT,WR_WAIT)+1).
- Elaboration error if RD_WAIT<1 or WR_WAIT<1.

Decomposition:
- Package sram_ctrl_pkg holds:
  - FSM state encodings (localparams, 3 bits).
  - Default timing constants (RD_WAIT/WR_WAIT defaults for the board's 10 ns part at 100 MHz).
- One sub-module, sram_wait_timer: loadable down-counter with a done flag, reused for the RD_ACCESS and WR_PULSE durations.
- FSM, address and word counters, and the tristate stay in sram_burst_ctrl.

Test Plan:
- Reset, then single write: addr=0x00010, wr_data=0xA5, len_m1=0 -> we_n low exactly 2 cycles, dq=0xA5 from WR_SETUP through WR_HOLD, wr_done pulses once, busy low after 4 cycles.
- Single read of 0x00010 against the SRAM model -> rd_valid at T0+4 with rd_data=0xA5; oe_n low exactly 2 cycles; dq never driven by the DUT.
- Write burst at 0x7FFFE, len_m1=3, data 0x11,0x22,0x33,0x44 supplied on wr_next -> three wr_next pulses; addresses 0x7FFFE,0x7FFFF,0x00000,0x00001 (wrap); read-back burst returns the same four bytes with four rd_valid pulses spaced RD_WAIT cycles apart.
- start held high continuously, including during busy -> exactly one operation per IDLE sample; no start accepted mid-burst.
- Assert reset during the 2nd WR_PULSE cycle of a 4-word burst -> same cycle: we_n=ce_n=1, dq=Z, busy=0; next start operates normally.
- Parameter sweep DATA_W=16, RD_WAIT=1, WR_WAIT=3, len_m1=255 -> 256 words correct; contention assertion (oe_n low while DQ driven) never fires.
